// File: rtl/drv_debug_hexmux.sv
// drv_debug_hexmux: multiplexes NUM_CH 32-bit debug channels onto NUM_DIGITS
// seven-segment digits. It supports a switch-selected live view, a freeze/hold
// toggle, timed auto-cycling through the channels, and a masked value trigger
// that freezes the display when it matches.
//
// Optional build macro: DRV_DEBUG_BLANK_EN enables leading-zero blanking.
//
// Ports:
//   CLK_I      system clock
//   reset      synchronous, active-high reset
//   ch_data    packed channels; channel c = ch_data[32c+31:32c]
//   sw_sel     live channel select (clamped to NUM_CH-1)
//   sw_freeze  freeze toggle; acts on its rising edge only
//   sw_auto    level; 1 = auto-cycle through the channels
//   trig_en    enables the value trigger
//   trig_value trigger compare value
//   trig_mask  1 = bit participates in the compare
//   hex        digit i = hex[8i+7:8i]; bit 7 = DP, bits 6:0 = segments g..a
//   active_ch  channel currently sourced or held
//   frozen     state is FROZEN
//   trig_hit   sticky; the freeze was caused by the trigger
module drv_debug_hexmux #(
  parameter int NUM_CH         = 4,
  parameter int SEL_W          = 2,
  parameter int NUM_DIGITS     = 8,
  parameter int CYCLE_DIV      = 30000000,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                    CLK_I,
  input  logic                    reset,
  input  logic [NUM_CH*32-1:0]    ch_data,
  input  logic [SEL_W-1:0]        sw_sel,
  input  logic                    sw_freeze,
  input  logic                    sw_auto,
  input  logic                    trig_en,
  input  logic [31:0]             trig_value,
  input  logic [31:0]             trig_mask,
  output logic [NUM_DIGITS*8-1:0] hex,
  output logic [3:0]              active_ch,
  output logic                    frozen,
  output logic                    trig_hit
);

  localparam int             PS_W       = $clog2(CYCLE_DIV);
  localparam logic [PS_W-1:0] PS_LAST   = PS_W'(CYCLE_DIV - 1);
  localparam logic [3:0]     LAST_CH    = 4'(NUM_CH - 1);
  localparam logic [7:0]     ZERO_GLYPH = (SEG_ACTIVE_LOW != 0) ? 8'hC0 : 8'h3F;

  typedef enum logic [1:0] {ST_LIVE, ST_AUTO, ST_FROZEN} state_t;

  state_t                  state_q;
  logic [31:0]             display_q;
  logic [3:0]              active_q;
  logic                    trig_hit_q;
  logic [PS_W-1:0]         ps_q;
  logic                    frz_q;
  logic [NUM_DIGITS*8-1:0] hex_q;
  logic [NUM_DIGITS*8-1:0] hex_d;

  logic [3:0]  sel_ext;
  logic [3:0]  sel_eff;
  logic [3:0]  src_idx;
  logic [31:0] src;
  logic        match;
  logic        frz_edge;
  logic        ps_term;
  logic [3:0]  active_next;

  // Active-high glyphs for one hex nibble, segments g..a.
  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'h3F;  4'h1: seg7 = 7'h06;  4'h2: seg7 = 7'h5B;  4'h3: seg7 = 7'h4F;
      4'h4: seg7 = 7'h66;  4'h5: seg7 = 7'h6D;  4'h6: seg7 = 7'h7D;  4'h7: seg7 = 7'h07;
      4'h8: seg7 = 7'h7F;  4'h9: seg7 = 7'h6F;  4'hA: seg7 = 7'h77;  4'hB: seg7 = 7'h7C;
      4'hC: seg7 = 7'h39;  4'hD: seg7 = 7'h5E;  4'hE: seg7 = 7'h79;  default: seg7 = 7'h71;
    endcase
  endfunction

  always_comb begin
    sel_ext     = 4'(sw_sel);
    sel_eff     = (sel_ext > LAST_CH) ? LAST_CH : sel_ext;
    // The trigger compares whatever channel is being captured this cycle.
    src_idx     = (state_q == ST_AUTO) ? active_q : sel_eff;
    src         = ch_data[32*src_idx +: 32];
    match       = trig_en && (((src ^ trig_value) & trig_mask) == 32'd0);
    frz_edge    = sw_freeze & ~frz_q;
    ps_term     = (ps_q == PS_LAST);
    active_next = (active_q == LAST_CH) ? 4'd0 : active_q + 4'd1;
  end

  // Stage 1: channel capture and mode control.
  always_ff @(posedge CLK_I) begin
    if (reset) begin
      state_q    <= ST_LIVE;
      display_q  <= 32'd0;
      active_q   <= 4'd0;
      trig_hit_q <= 1'b0;
      ps_q       <= '0;
      frz_q      <= 1'b1;
    end else begin
      frz_q <= sw_freeze;
      case (state_q)
        ST_LIVE: begin
          active_q  <= sel_eff;
          display_q <= src;
          if (frz_edge) begin
            state_q <= ST_FROZEN;
          end else if (match) begin
            state_q    <= ST_FROZEN;
            trig_hit_q <= 1'b1;
          end else if (sw_auto) begin
            state_q <= ST_AUTO;
            ps_q    <= '0;
          end
        end
        ST_AUTO: begin
          display_q <= src;
          ps_q      <= ps_term ? '0 : ps_q + PS_W'(1);
          if (frz_edge) begin
            state_q <= ST_FROZEN;
          end else if (match) begin
            state_q    <= ST_FROZEN;
            trig_hit_q <= 1'b1;
          end else if (!sw_auto) begin
            state_q <= ST_LIVE;
          end else if (ps_term) begin
            // Advance only while staying in AUTO so a held channel matches
            // the value that was captured with it.
            active_q <= active_next;
          end
        end
        ST_FROZEN: begin
          if (frz_edge) begin
            state_q    <= ST_LIVE;
            trig_hit_q <= 1'b0;
          end
        end
        default: state_q <= ST_LIVE;
      endcase
    end
  end

  always_comb begin
    logic [NUM_DIGITS-1:0] blank;
    logic [7:0]            dig;
`ifdef DRV_DEBUG_BLANK_EN
    logic                  zero_run;
`endif
    blank = '0;
    hex_d = '0;
    dig   = 8'd0;
`ifdef DRV_DEBUG_BLANK_EN
    // Digit i blanks when it and every shown digit above it are zero.
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_run = zero_run & (display_q[4*i +: 4] == 4'd0);
      blank[i] = zero_run;
    end
`endif
    for (int i = 0; i < NUM_DIGITS; i++) begin
      dig[6:0] = blank[i] ? 7'd0 : seg7(display_q[4*i +: 4]);
      dig[7]   = ((i == 0) && (state_q == ST_FROZEN)) ||
                 ((i == NUM_DIGITS - 1) && (state_q == ST_AUTO));
      hex_d[8*i +: 8] = (SEG_ACTIVE_LOW != 0) ? ~dig : dig;
    end
  end

  // Stage 2: registered segment encode.
  always_ff @(posedge CLK_I) begin
    if (reset) begin
      hex_q <= {NUM_DIGITS{ZERO_GLYPH}};
    end else begin
      hex_q <= hex_d;
    end
  end

  assign hex       = hex_q;
  assign active_ch = active_q;
  assign frozen    = (state_q == ST_FROZEN);
  assign trig_hit  = trig_hit_q;

endmodule

// File: tb/tb_drv_debug_hexmux.sv
module tb_drv_debug_hexmux;

  logic        clk = 1'b0;
  logic        reset;
  logic [95:0] ch_data;
  logic [1:0]  sw_sel;
  logic        sw_freeze, sw_auto, trig_en;
  logic [31:0] trig_value, trig_mask;
  logic [63:0] hex;
  logic [3:0]  active_ch;
  logic        frozen, trig_hit;
  logic [31:0] c0, c1, c2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;
  assign ch_data = {c2, c1, c0};

  drv_debug_hexmux #(
    .NUM_CH(3), .SEL_W(2), .NUM_DIGITS(8), .CYCLE_DIV(4), .SEG_ACTIVE_LOW(1)
  ) dut (
    .CLK_I(clk), .reset(reset), .ch_data(ch_data), .sw_sel(sw_sel),
    .sw_freeze(sw_freeze), .sw_auto(sw_auto), .trig_en(trig_en),
    .trig_value(trig_value), .trig_mask(trig_mask), .hex(hex),
    .active_ch(active_ch), .frozen(frozen), .trig_hit(trig_hit)
  );

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] d0, d1, d2;
    logic [3:0]  exp_ch;
    logic [31:0] exp_disp;
  } vec_t;

  vec_t vecs[4];

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'h3F;  4'h1: glyph = 7'h06;  4'h2: glyph = 7'h5B;  4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;  4'h5: glyph = 7'h6D;  4'h6: glyph = 7'h7D;  4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;  4'h9: glyph = 7'h6F;  4'hA: glyph = 7'h77;  4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;  4'hD: glyph = 7'h5E;  4'hE: glyph = 7'h79;  default: glyph = 7'h71;
    endcase
  endfunction

  // Expected active-low hex bus for a displayed word and the two DP flags.
  function automatic logic [63:0] exp_hex(input logic [31:0] d, input logic dp0, input logic dp7);
    logic [63:0] r;
    logic [7:0]  b;
`ifdef DRV_DEBUG_BLANK_EN
    logic        zr;
    zr = 1'b1;
`endif
    r = '0;
    for (int i = 7; i >= 0; i--) begin
      b[6:0] = glyph(d[4*i +: 4]);
`ifdef DRV_DEBUG_BLANK_EN
      if (i > 0) begin
        zr = zr && (d[4*i +: 4] == 4'd0);
        if (zr) b[6:0] = 7'd0;
      end
`endif
      b[7] = ((i == 0) && dp0) || ((i == 7) && dp7);
      r[8*i +: 8] = ~b;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{sel: 2'd2, d0: 32'h1111_2222, d1: 32'h3333_4444, d2: 32'h00DF_F01C,
                exp_ch: 4'd2, exp_disp: 32'h00DF_F01C};
    vecs[1] = '{sel: 2'd3, d0: 32'h1111_2222, d1: 32'h3333_4444, d2: 32'hCAFE_BABE,
                exp_ch: 4'd2, exp_disp: 32'hCAFE_BABE};
    vecs[2] = '{sel: 2'd0, d0: 32'h8765_4321, d1: 32'h3333_4444, d2: 32'hCAFE_BABE,
                exp_ch: 4'd0, exp_disp: 32'h8765_4321};
    vecs[3] = '{sel: 2'd1, d0: 32'h8765_4321, d1: 32'hFEDC_BA98, d2: 32'hCAFE_BABE,
                exp_ch: 4'd1, exp_disp: 32'hFEDC_BA98};

    reset = 1'b1; sw_sel = 2'd0; sw_freeze = 1'b1; sw_auto = 1'b0; trig_en = 1'b0;
    trig_value = 32'd0; trig_mask = 32'd0; c0 = 32'd0; c1 = 32'd0; c2 = 32'd0;

    // Reset state, freeze switch already high.
    step(2);
    chk("rst_hex", hex, 64'hC0C0_C0C0_C0C0_C0C0);
    chk("rst_frozen", {63'd0, frozen}, 64'd0);
    chk("rst_trig_hit", {63'd0, trig_hit}, 64'd0);
    chk("rst_active", {60'd0, active_ch}, 64'd0);
    reset = 1'b0;
    step(10);
    chk("held_freeze_live", {63'd0, frozen}, 64'd0);
    chk("held_freeze_hex", hex, exp_hex(32'd0, 1'b0, 1'b0));
    sw_freeze = 1'b0;
    step(1);

    // Live view table, including the select clamp.
    for (int v = 0; v < 4; v++) begin
      sw_sel = vecs[v].sel; c0 = vecs[v].d0; c1 = vecs[v].d1; c2 = vecs[v].d2;
      step(2);
      chk($sformatf("live%0d_active", v), {60'd0, active_ch}, {60'd0, vecs[v].exp_ch});
      chk($sformatf("live%0d_hex", v), hex, exp_hex(vecs[v].exp_disp, 1'b0, 1'b0));
`ifndef DRV_DEBUG_BLANK_EN
      if (v == 0) chk("live_hex_literal", hex, 64'hC0C0_A18E_8EC0_F9C6);
`endif
    end

    // Auto-cycle from channel 1 with a 4-cycle step.
    c0 = 32'h1234_5678; c1 = 32'h9ABC_DEF0; c2 = 32'h0F1E_2D3C;
    sw_sel = 2'd1; sw_auto = 1'b1;
    step(1);
    chk("auto_e0_active", {60'd0, active_ch}, 64'd1);
    step(1);
    chk("auto_e1_hex", hex, exp_hex(32'h9ABC_DEF0, 1'b0, 1'b1));
    step(2);
    chk("auto_e3_active", {60'd0, active_ch}, 64'd1);
    step(1);
    chk("auto_e4_active", {60'd0, active_ch}, 64'd2);
    chk("auto_e4_hex", hex, exp_hex(32'h9ABC_DEF0, 1'b0, 1'b1));
    step(4);
    chk("auto_e8_active", {60'd0, active_ch}, 64'd0);
    step(1);
    chk("auto_e9_hex", hex, exp_hex(32'h0F1E_2D3C, 1'b0, 1'b1));
    step(3);
    chk("auto_e12_active", {60'd0, active_ch}, 64'd1);
    sw_auto = 1'b0;
    step(2);
    chk("auto_exit_hex", hex, exp_hex(32'h9ABC_DEF0, 1'b0, 1'b0));
    chk("auto_exit_active", {60'd0, active_ch}, 64'd1);

    // Masked trigger on a ramping channel 0.
    sw_sel = 2'd0; c0 = 32'h00FB_FFFE;
    trig_en = 1'b1; trig_mask = 32'hFFFF_0000; trig_value = 32'h00FC_0000;
    step(1);
    chk("trig_nomatch0", {63'd0, frozen}, 64'd0);
    c0 = 32'h00FB_FFFF;
    step(1);
    chk("trig_nomatch1", {63'd0, frozen}, 64'd0);
    c0 = 32'h00FC_0000;
    step(1);
    chk("trig_frozen", {63'd0, frozen}, 64'd1);
    chk("trig_hit", {63'd0, trig_hit}, 64'd1);
    c0 = 32'h00FC_0001;
    step(1);
    chk("trig_hex", hex, exp_hex(32'h00FC_0000, 1'b1, 1'b0));
    c0 = 32'h00FD_0000;
    step(3);
    chk("trig_hold_hex", hex, exp_hex(32'h00FC_0000, 1'b1, 1'b0));
    chk("trig_hold_active", {60'd0, active_ch}, 64'd0);

    // Freeze pulse releases the hold and clears trig_hit.
    sw_freeze = 1'b1;
    step(1);
    chk("unfreeze_frozen", {63'd0, frozen}, 64'd0);
    chk("unfreeze_trig_hit", {63'd0, trig_hit}, 64'd0);
    sw_freeze = 1'b0;
    step(1);

    // Freeze edge and trigger match on the same edge: freeze wins.
    c0 = 32'h00FC_1234; sw_freeze = 1'b1;
    step(1);
    chk("both_frozen", {63'd0, frozen}, 64'd1);
    chk("both_trig_hit", {63'd0, trig_hit}, 64'd0);
    step(1);
    chk("both_hex", hex, exp_hex(32'h00FC_1234, 1'b1, 1'b0));
    step(3);
    chk("both_stays_frozen", {63'd0, frozen}, 64'd1);

    // Reset out of FROZEN with trig_hit set.
    sw_freeze = 1'b0;
    step(1);
    sw_freeze = 1'b1;
    step(1);
    chk("rearm_live", {63'd0, frozen}, 64'd0);
    step(1);
    chk("rearm_trig_hit", {63'd0, trig_hit}, 64'd1);
    reset = 1'b1;
    step(1);
    chk("midrst_frozen", {63'd0, frozen}, 64'd0);
    chk("midrst_trig_hit", {63'd0, trig_hit}, 64'd0);
    chk("midrst_active", {60'd0, active_ch}, 64'd0);
    chk("midrst_hex", hex, 64'hC0C0_C0C0_C0C0_C0C0);
    reset = 1'b0; trig_en = 1'b0; sw_freeze = 1'b0;

    // Leading digits of a small value, and an all-zero value.
    sw_sel = 2'd0; c0 = 32'h0000_00A5;
    step(2);
`ifdef DRV_DEBUG_BLANK_EN
    chk("small_hex", hex, 64'hFFFF_FFFF_FFFF_8892);
`else
    chk("small_hex", hex, 64'hC0C0_C0C0_C0C0_8892);
`endif
    c0 = 32'd0;
    step(2);
`ifdef DRV_DEBUG_BLANK_EN
    chk("zero_hex", hex, 64'hFFFF_FFFF_FFFF_FFC0);
`else
    chk("zero_hex", hex, 64'hC0C0_C0C0_C0C0_C0C0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/drv_debug_hexmux.md
Name: drv_debug_hexmux

Overview:
- Parametrised successor to the single-purpose debug hex driver.
- Multiplexes NUM_CH 32-bit debug channels onto NUM_DIGITS seven-segment digits.
- Switch-selected live view, freeze/hold, timed auto-cycle through channels, and a masked value trigger that freezes the display on a match.
- Sits at board top level between core debug buses (PC, master address, syscon/track) and the hex LEDs and switches.

Parameters:
- NUM_CH, 4: number of 32-bit channels (2..16).
- SEL_W, 2: width of channel-select switch bus; 2**SEL_W >= NUM_CH.
- NUM_DIGITS, 8: digits driven (1..8); digit i shows display[4i+3:4i].
- CYCLE_DIV, 30000000: CLK_I cycles per auto-cycle step (>= 2).
- SEG_ACTIVE_LOW, 1: 1 = segments and decimal point inverted at output (DE2-70 style).

Ports:
- CLK_I  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ch_data  in  NUM_CH*32  channel c = ch_data[32c+31:32c].
- sw_sel  in  SEL_W  live channel select.
- sw_freeze  in  1  freeze toggle; acts on rising edge only.
- sw_auto  in  1  level; 1 = auto-cycle channels.
- trig_en  in  1  enables the value trigger.
- trig_value  in  32  trigger compare value.
- trig_mask  in  32  1 = bit participates in the compare.
- hex  out  NUM_DIGITS*8  digit i = hex[8i+7:8i]; bit 7 is the decimal point, bits 6:0 are segments g..a.
- active_ch  out  4  channel currently sourced or held.
- frozen  out  1  state is FROZEN.
- trig_hit  out  1  sticky; the freeze was caused by the trigger.

Behaviour:
- Clock and reset: single clock CLK_I. Reset is synchronous and active-high.
- Reset values:
  - state = LIVE; display = 0; active_ch = 0; frozen = 0; trig_hit = 0; prescaler = 0.
  - Freeze edge register = 1, so a switch already high at reset produces no edge.
  - hex = encoded "0" on every digit with DP off: 8'hC0 per digit when SEG_ACTIVE_LOW = 1, 8'h3F otherwise.
- Select clamp: sel_eff = min(sw_sel, NUM_CH-1).
- Trigger: match = trig_en && (((src ^ trig_value) & trig_mask) == 0), where src = ch_data of the channel being sampled this cycle.
- Frz_edge = sw_freeze & ~sw_freeze_d.
- State machine (priority within a state: frz_edge > match > sw_auto):
  - LIVE:
    - active_ch <= sel_eff; display <= ch[sel_eff].
    - frz_edge -> FROZEN.
    - match -> FROZEN, trig_hit <= 1; display still captures the matching value on this edge.
    - sw_auto -> AUTO; prescaler <= 0; active_ch <= sel_eff.
  - AUTO:
    - display <= ch[active_ch].
    - Prescaler counts 0..CYCLE_DIV-1; at terminal count it wraps to 0 and active_ch <= (active_ch == NUM_CH-1) ? 0 : active_ch+1.
    - frz_edge -> FROZEN.
    - match -> FROZEN with trig_hit.
    - !sw_auto -> LIVE.
  - FROZEN:
    - display and active_ch hold; trigger ignored.
    - frz_edge -> LIVE; trig_hit <= 0.
- Latency: inputs sampled at edge k appear on hex after edge k+1 (display reg, then registered segment encode).
- frozen, trig_hit and active_ch are registered, coincident with display.
- Encoding (0..F): 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71, inverted when SEG_ACTIVE_LOW = 1.
- Decimal points:
  - Digit 0 DP lit while frozen.
  - Digit NUM_DIGITS-1 DP lit while in AUTO.
- Display width: display is 32 bits; with NUM_DIGITS < 8, upper nibbles are not shown.
- Reset mid-operation (e.g. FROZEN with trig_hit): next edge gives full reset values.

Optional Feature:
- Macro: DRV_DEBUG_BLANK_EN.
- Defined: leading-zero blanking. Digit i is blanked (all segments off, DP rules unchanged) when i > 0 and display[31:4i] == 0 within the shown digits. Digit 0 is never blanked. Blank masks are registered alongside the segments, so latency is unchanged.
- Undefined: all digits are always driven.

Test Plan:
- Reset with sw_freeze = 1 -> hex = 64'hC0C0C0C0C0C0C0C0, frozen = 0; holding sw_freeze high for 10 cycles stays LIVE.
- sw_sel = 2, ch2 = 32'h00DF_F01C -> hex digits (hi..lo) show 00DFF01C two edges later, active_ch = 2. sw_sel = 3 with NUM_CH = 3 -> clamps to channel 2.
- CYCLE_DIV = 4, NUM_CH = 3, sw_auto = 1 from sel 1 -> active_ch sequence 1,2,0,1 changing every 4 cycles; digit 7 DP lit; sw_auto = 0 -> LIVE on next edge.
- trig_en = 1, mask = 32'hFFFF_0000, value = 32'h00FC_0000; ch0 ramps 32'h00FB_FFFE.. -> freezes on 32'h00FC_0000, trig_hit = 1, digit 0 DP lit; further ramp does not change hex.
- sw_freeze pulse while FROZEN -> LIVE, trig_hit = 0. Same-cycle frz_edge and match in LIVE -> FROZEN with trig_hit = 0.
- With DRV_DEBUG_BLANK_EN: display 32'h0000_00A5 -> digits 7..2 blank, digits show "A5". display 0 -> only digit 0 shows "0".
